ram_arbiter: RTL

- Round-robin arbiter that shares the single-ported main RAM among NREQ cache requesters (icache/dcache ports of all cores) on the memory side of the coherence controller.
- Grants one requester at a time and holds the grant for a complete single-word or block (BLOCK_WORDS) transfer.
- Generates the per-word RAM addresses and returns per-requester wait, load and error indications.
- Fairness comes from a rotating priority pointer.

---
 rtl/ram_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing the single-ported main RAM among
// NREQ cache requesters. It grants one requester at a time for a whole
// single-word or BLOCK_WORDS burst and generates the per-word RAM address.
// Fairness comes from a rotating priority pointer.
//
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   req_ren      per-requester read request
//   req_wen      per-requester write request (wins if both are set)
//   req_burst    per-requester burst select, sampled at grant
//   req_addr     per-requester base byte address, sampled at grant
//   req_store    per-requester write data, read live for each word
//   req_wait     per-requester wait, low for one cycle per completed word
//   req_load     RAM read data routed to the granted requester's slice
//   req_err      per-requester RAM error pulse
//   ramREN/ramWEN/ramaddr/ramstore  RAM command side
//   ramload/ramstate                RAM response side
module ram_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned BLOCK_WORDS = 2,
  parameter int unsigned WORD_W      = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_ren,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ-1:0]          req_burst,
  input  logic [NREQ*WORD_W-1:0]   req_addr,
  input  logic [NREQ*WORD_W-1:0]   req_store,
  output logic [NREQ-1:0]          req_wait,
  output logic [NREQ*WORD_W-1:0]   req_load,
  output logic [NREQ-1:0]          req_err,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(BLOCK_WORDS + 1);

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   gnt, gnt_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   len, len_n;
  logic [WORD_W-1:0]  base, base_n;
  logic               is_wr, is_wr_n;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   gnt_next;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      cnt   <= '0;
      len   <= '0;
      base  <= '0;
      is_wr <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      cnt   <= cnt_n;
      len   <= len_n;
      base  <= base_n;
      is_wr <= is_wr_n;
    end
  end

  // Round-robin winner search starting at ptr
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin : scan
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(ptr) + i) % int'(NREQ));
      if (!found && (req_ren[cand] || req_wen[cand])) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign gnt_next = IDX_W'((int'(gnt) + 1) % int'(NREQ));

  // Next-state and output logic
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    gnt_n    = gnt;
    cnt_n    = cnt;
    len_n    = len;
    base_n   = base;
    is_wr_n  = is_wr;
    req_wait = '1;
    req_load = '0;
    req_err  = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state)
      IDLE: begin
        if (found) begin
          gnt_n   = win;
          base_n  = req_addr[int'(win)*int'(WORD_W) +: WORD_W];
          is_wr_n = req_wen[win];
          len_n   = req_burst[win] ? CNT_W'(BLOCK_WORDS) : CNT_W'(1);
          cnt_n   = '0;
          state_n = XFER;
        end
      end
      XFER: begin
        ramREN   = ~is_wr;
        ramWEN   = is_wr;
        ramaddr  = base + (WORD_W'(cnt) << 2);
        ramstore = req_store[int'(gnt)*int'(WORD_W) +: WORD_W];
        case (ramstate)
          RAM_FREE, RAM_BUSY: begin
          end
          RAM_ACCESS: begin
            req_wait[gnt] = 1'b0;
            req_load[int'(gnt)*int'(WORD_W) +: WORD_W] = ramload;
            cnt_n = cnt + CNT_W'(1);
            if (cnt == len - CNT_W'(1)) begin
              ptr_n   = gnt_next;
              state_n = IDLE;
            end else begin
              state_n = GAP;
            end
          end
          RAM_ERROR: begin
            req_err[gnt]  = 1'b1;
            req_wait[gnt] = 1'b0;
            ptr_n         = gnt_next;
            state_n       = IDLE;
          end
        endcase
      end
      GAP: begin
        state_n = XFER;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Reset aborts any transfer and presents idle outputs in the same cycle
    if (RST) begin
      req_wait = '1;
      req_load = '0;
      req_err  = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
    end
  end

endmodule
